inst_fetch: RTL and testbench

Instruction fetch stage for the RV32I core. Holds the program counter and issues word fetches to instruction memory over a request/response interface. Buffers returned instructions in a small in-order queue and presents them, with their PC, to decode over a valid/ready handshake; decode's immediate extension and control decode consume `inst`. Accepts redirects (branch/jump targets computed from the extended immediate) from execute, flushing queued and in-flight fetches.

---
 rtl/inst_fetch.sv | 114 +++++++++++
 tb/tb_inst_fetch.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, keeps queued plus outstanding fetches within
// DEPTH, and buffers returned words in order for decode. Redirects flush all of it.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;

  logic          pop;
  logic          req_fire;
  logic          drop;
  logic          push;
  logic [SW-1:0] inflight_c;
  logic [CW-1:0] out_after_rsp;
  logic [31:0]   redirect_base;
  logic          unused_redirect_lsbs;

  // Credit check counts the slot freed by this cycle's pop.
  assign pop            = inst_valid & inst_ready;
  assign inflight_c     = SW'(count) + SW'(out_cnt) - SW'(pop);
  assign imem_req_valid = ~rst & ~redirect_valid & (inflight_c < SW'(DEPTH));
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign drop           = imem_rsp_valid & (redirect_valid | (drop_cnt != '0));
  assign push           = imem_rsp_valid & ~drop;
  assign out_after_rsp  = out_cnt - CW'(imem_rsp_valid);

  assign redirect_base        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req_addr = fetch_pc;
  assign inst_valid    = (count != '0);
  assign inst          = q_inst[rd_ptr];
  assign inst_pc       = q_pc[rd_ptr];

  // rsp_pc tracks the address of the next non-stale response: responses return in
  // order and surviving ones are sequential from the last redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= redirect_base;
      rsp_pc   <= redirect_base;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_cnt  <= out_after_rsp;
      drop_cnt <= out_after_rsp;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      out_cnt <= out_after_rsp + CW'(req_fire);
      if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        q_inst[wr_ptr] <= imem_rsp_data;
        q_pc[wr_ptr]   <= rsp_pc;
        wr_ptr         <= wr_ptr + PW'(1);
        rsp_pc         <= rsp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue occupancy never exceeds its storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run checked
// against a PC-stream reference model and an in-order variable-latency memory model.
module tb_inst_fetch;

  localparam logic [31:0] RPC     = 32'h0000_0100;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;

  logic        w_req_valid;
  logic        w_req_ready = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data  = 32'h0;
  logic        w_inst_valid;
  logic        w_inst_ready = 1'b1;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc    = 32'h0;

  inst_fetch #(.RESET_PC(RPC), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  inst_fetch #(.RESET_PC(WRAP_PC), .DEPTH(2)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned req_ready_pct = 100;
  int          last_due = 0;
  mreq_t       mq[$];
  logic [31:0] w_addrs[$];
  logic        w_pend = 1'b0;
  logic [31:0] w_pend_addr = 32'h0;

  logic        s_req_valid, s_inst_valid, s_pop, s_fire;
  logic [31:0] s_req_addr, s_inst, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock: present memory responses, sample at negedge, advance to posedge+1.
  task automatic clock_cycle();
    mreq_t       r;
    int unsigned lat;
    if (rst) begin
      mq.delete();
      w_pend = 1'b0;
    end
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    w_rsp_valid    = w_pend;
    w_rsp_data     = mem_word(w_pend_addr);
    imem_req_ready = ($urandom_range(99, 0) < req_ready_pct);
    @(negedge clk);
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst       = inst;
    s_pc         = inst_pc;
    s_pop        = inst_valid & inst_ready;
    s_fire       = imem_req_valid & imem_req_ready;
    if (imem_rsp_valid) void'(mq.pop_front());
    if (s_fire) begin
      lat    = $urandom_range(lat_max, lat_min);
      r.addr = imem_req_addr;
      r.due  = (cyc + int'(lat) > last_due) ? cyc + int'(lat) : last_due + 1;
      last_due = r.due;
      mq.push_back(r);
    end
    if (w_req_valid) w_addrs.push_back(w_req_addr);
    w_pend      = w_req_valid;
    w_pend_addr = w_req_addr;
    if (rst) begin
      mq.delete();
      last_due = 0;
      w_addrs.delete();
      w_pend = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    clock_cycle();
    clock_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    req_ready_pct = 100;
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 3; i++) begin
      clock_cycle();
      checks++;
      if (s_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_req_valid cyc%0d: got %b want 0", i, s_req_valid);
      end
      checks++;
      if ({s_inst_valid, s_inst, s_pc} !== 65'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got v=%b inst=%h pc=%h want all 0", i, s_inst_valid, s_inst, s_pc);
      end
    end
    rst = 1'b0;
    clock_cycle();
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RPC) begin
      errors++;
      $display("FAIL first_request: got v=%b addr=%h want v=1 addr=%h", s_req_valid, s_req_addr, RPC);
    end
  endtask

  // Continues right after test_reset: the request for RESET_PC was accepted already.
  task automatic test_stream();
    logic [31:0] exp_pc = RPC;
    int got = 0;
    int first_i = -1;
    inst_ready = 1'b1;
    for (int i = 0; i < 20 && got < 8; i++) begin
      clock_cycle();
      if (got == 0 && s_inst_valid) first_i = i;
      if (got > 0 || s_inst_valid) begin
        checks++;
        if (s_inst_valid !== 1'b1 || s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL stream_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                   got, s_inst_valid, s_pc, s_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        got++;
      end
    end
    checks++;
    if (first_i != 1 || got != 8) begin
      errors++;
      $display("FAIL stream_timing: got first=%0d count=%0d want first=1 count=8", first_i, got);
    end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    int got = 0;
    logic [31:0] exp_pc = RPC;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clock_cycle();
      if (s_fire) fires++;
      if (i >= 2) begin
        checks++;
        if (s_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_no_request cyc%0d: got %b want 0", i, s_req_valid);
        end
      end
    end
    checks++;
    if (fires != 2 || s_inst_valid !== 1'b1 || s_pc !== RPC) begin
      errors++;
      $display("FAIL bp_saturate: got fires=%0d v=%b pc=%h want fires=2 v=1 pc=%h", fires, s_inst_valid, s_pc, RPC);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 15 && got < 3; i++) begin
      clock_cycle();
      if (s_pop) begin
        checks++;
        if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL bp_release_%0d: got pc=%h inst=%h want pc=%h inst=%h", got, s_pc, s_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        got++;
      end
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL bp_release_count: got %0d want 3", got);
    end
  endtask

  task automatic test_redirect();
    logic seen_req = 1'b0;
    int got = 0;
    logic [31:0] exp_pc = 32'h0000_0200;
    lat_min = 3;
    lat_max = 3;
    do_reset();
    inst_ready = 1'b1;
    clock_cycle();
    clock_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    clock_cycle();
    checks++;
    if (s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_blocks_req: got %b want 0", s_req_valid);
    end
    redirect_valid = 1'b0;
    for (int i = 0; i < 25 && got < 2; i++) begin
      clock_cycle();
      if (s_req_valid && !seen_req) begin
        seen_req = 1'b1;
        checks++;
        if (s_req_addr !== 32'h0000_0200) begin
          errors++;
          $display("FAIL redirect_req_addr: got %h want 00000200", s_req_addr);
        end
      end
      if (s_pop) begin
        checks++;
        if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL redirect_deliver_%0d: got pc=%h inst=%h want pc=%h inst=%h", got, s_pc, s_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        got++;
      end
    end
    checks++;
    if (got != 2 || !seen_req) begin
      errors++;
      $display("FAIL redirect_progress: got delivered=%0d req=%b want 2 and 1", got, seen_req);
    end
    lat_min = 1;
    lat_max = 1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr = WRAP_PC;
    do_reset();
    for (int i = 0; i < 6; i++) clock_cycle();
    checks++;
    if (w_addrs.size() < 4) begin
      errors++;
      $display("FAIL wrap_count: got %0d requests want at least 4", w_addrs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (w_addrs[i] !== exp_addr) begin
          errors++;
          $display("FAIL wrap_addr_%0d: got %h want %h", i, w_addrs[i], exp_addr);
        end
        exp_addr += 32'd4;
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    inst_ready = 1'b0;
    clock_cycle();
    clock_cycle();
    rst = 1'b1;
    clock_cycle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clock_cycle();
      checks++;
      if (s_inst_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== RPC + 32'(4 * i)) begin
        errors++;
        $display("FAIL midreset_cyc%0d: got v=%b req=%b addr=%h want v=0 req=1 addr=%h",
                 i, s_inst_valid, s_req_valid, s_req_addr, RPC + 32'(4 * i));
      end
    end
  endtask

  // Reference: decode sees a sequential PC stream restarting at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc = RPC;
    int pops = 0;
    lat_min = 1;
    lat_max = 4;
    req_ready_pct = 70;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      inst_ready     = ($urandom_range(99, 0) < 75);
      redirect_valid = ($urandom_range(99, 0) < 4);
      redirect_pc    = $urandom;
      clock_cycle();
      if (s_req_valid) begin
        checks++;
        if (s_req_addr[1:0] !== 2'b00 || redirect_valid) begin
          errors++;
          $display("FAIL rand_req cyc%0d: got addr=%h redirect=%b want aligned, no redirect", cyc, s_req_addr, redirect_valid);
        end
      end
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (s_pop) begin
        checks++;
        if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rand_deliver cyc%0d: got pc=%h inst=%h want pc=%h inst=%h", cyc, s_pc, s_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        pops++;
      end
    end
    redirect_valid = 1'b0;
    checks++;
    if (pops < 300) begin
      errors++;
      $display("FAIL rand_progress: got %0d deliveries want at least 300", pops);
    end
    req_ready_pct = 100;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
